upp_tx_sequencer: RTL and testbench
===================================

# upp_tx_sequencer

Parametrised uPP transmit sequencer; successor to the single-channel GPIO_5/GPIO_0 frame solver. Drains one of N show-ahead FIFOs (BLVDS receive side) onto the DSP uPP bus in fixed-length lines, honouring a real receiver WAIT. Frame handshake: DSP raises GPIO_5 → lines → GPIO_0 with stimulus words → inter-frame gap. New over the previous generation: channel count, width, line length, lines-per-frame, partial-line flush with padding, per-line START mode, underrun flag.

## Interface
- DATA_W, 16, uPP data width
- USEDW_W, 9, FIFO usedw width
- N_CH, 2, number of source FIFOs (≥1); CH_W = max(1,$clog2(N_CH))
- LINE_LEN, 256, words per uPP line (≥2)
- THRESHOLD, 256, usedw level that starts a line (LINE_LEN ≤ THRESHOLD < 2^USEDW_W)
- LINES_PER_FRAME, 0, lines per frame; 0 = unlimited (frame ends only via flush)
- START_EVERY_LINE, 0, 1: oSTART on first word of every line; 0: first line of frame only
- CHECK_GPIO5, 100, stimulus period in GPIO0 state (cycles)
- BETWEEN_FRAMES, 100, inter-frame gap (cycles)
- PAD_WORD, 0, pad/stimulus data value
- iCLK  in  1  clock
- iRST_N  in  1  asynchronous active-low reset
- iGPIO5  in  1  DSP ready (level)
- iSEL_CHANNEL  in  CH_W  channel request, sampled at frame start
- iWAIT  in  1  receiver pause request
- iFLUSH  in  1  end-of-frame pulse from BLVDS receiver
- iEMPTY  in  N_CH  per-FIFO empty
- iUSEDW  in  N_CH*USEDW_W  packed usedw, channel 0 in LSBs
- iFIFO_OUT  in  N_CH*DATA_W  packed show-ahead data
- oRD_REQ  out  N_CH  one-hot read acknowledge
- oDATA_UPP  out  DATA_W  uPP data
- oENA  out  1  uPP enable
- oSTART  out  1  uPP line start
- oGPIO_0  out  1  frame done to DSP
- oSEL_CHANNEL  out  CH_W  latched channel
- oERR  out  1  sticky: underrun or illegal channel
- oBUSY  out  1  state ≠ IDLE

## Operation
- Reset: all outputs 0, state IDLE, counters and flush latch 0.
- IDLE: oGPIO_0=0. On iGPIO5=1 latch channel (iSEL_CHANNEL ≥ N_CH → channel 0, oERR=1), clear oERR otherwise, line_cnt=0 → ARM.
- ARM: usedw(sel) ≥ THRESHOLD, or flush latched and !empty(sel) → READ, word_cnt=0. Flush latched and empty(sel) at a line boundary → GPIO0.
- READ: each cycle with !iWAIT: if !empty(sel) assert oRD_REQ[sel], emit word; else if flush latched emit PAD_WORD (no read); else stall, set oERR. iWAIT=1: no read, oENA=0, counters hold, oERR untouched. Emitted word with word_cnt=LINE_LEN-1 ends line: line_cnt++; line_cnt+1 == LINES_PER_FRAME (≠0) → GPIO0, else ARM.
- GPIO0: oGPIO_0=1. While iGPIO5=1: count to CHECK_GPIO5, then emit one PAD_WORD (oENA=1 one cycle), restart count. iGPIO5=0 → GAP, oENA=0.
- GAP: oGPIO_0=0, count BETWEEN_FRAMES cycles → IDLE; flush latch cleared.
- iFLUSH latched sticky from ARM/READ; ignored in IDLE/GPIO0/GAP.

## Timing
- oRD_REQ combinational from state, iWAIT, iEMPTY; data captured same edge → oDATA_UPP/oENA/oSTART registered, 1-cycle latency.
- oSTART high with first word (word_cnt=0) of line 0, or every line if START_EVERY_LINE.
- Back-to-back lines: ARM evaluated in the cycle after line end; ≥1 idle cycle between lines.
- Counters: word_cnt $clog2(LINE_LEN) bits, line_cnt 16 bits saturating.
- Async reset mid-line drops the line; no partial recovery.

## Structure
- Package upp_tx_pkg: state enum (IDLE, ARM, READ, GPIO0, GAP), shared default constants.
- Sub-module upp_ch_mux: selects empty/usedw/data by channel, decodes one-hot rdreq.

## Test plan
- N_CH=2, sel=1, usedw=256, LINES_PER_FRAME=2 → 512 words on ch1 only, oSTART once, oGPIO_0 after word 511.
- iWAIT high 5 cycles at word 100 → oENA low exactly 5 cycles, no rdreq, word 100 resumes unchanged.
- 40 words then iFLUSH → 40 data + 216 PAD_WORD, then GPIO0.
- FIFO empty mid-line, no flush → stall, oERR=1, resumes when data arrives.
- GPIO0 with iGPIO5 held 250 cycles → 2 stimulus pulses; GPIO5 falls → 100-cycle gap → IDLE.
- iRST_N low mid-READ → all outputs 0 immediately.

Source files
------------

// File: rtl/upp_tx_pkg.sv
// Shared types and default constants for the uPP transmit sequencer.
package upp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_READ,
        ST_GPIO0,
        ST_GAP
    } state_e;

    localparam int DEF_DATA_W           = 16;
    localparam int DEF_USEDW_W          = 9;
    localparam int DEF_N_CH             = 2;
    localparam int DEF_LINE_LEN         = 256;
    localparam int DEF_THRESHOLD        = 256;
    localparam int DEF_LINES_PER_FRAME  = 0;
    localparam int DEF_START_EVERY_LINE = 0;
    localparam int DEF_CHECK_GPIO5      = 100;
    localparam int DEF_BETWEEN_FRAMES   = 100;
    localparam int DEF_PAD_WORD         = 0;
    localparam int LINE_CNT_W           = 16;

    // Channel-select width; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/upp_ch_mux.sv
// Channel mux: picks empty/usedw/data of the selected FIFO and turns a
// single read enable into the one-hot read request vector.
module upp_ch_mux
    import upp_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int USEDW_W = DEF_USEDW_W,
    parameter int N_CH    = DEF_N_CH,
    parameter int CH_W    = ch_width(DEF_N_CH)
) (
    input  logic [CH_W-1:0]         sel_i,
    input  logic                    rd_en_i,
    input  logic [N_CH-1:0]         empty_i,
    input  logic [N_CH*USEDW_W-1:0] usedw_i,
    input  logic [N_CH*DATA_W-1:0]  data_i,
    output logic                    empty_o,
    output logic [USEDW_W-1:0]      usedw_o,
    output logic [DATA_W-1:0]       data_o,
    output logic [N_CH-1:0]         rd_req_o
);

    logic [USEDW_W-1:0] usedw_arr [N_CH];
    logic [DATA_W-1:0]  data_arr  [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign usedw_arr[gi] = usedw_i[gi*USEDW_W +: USEDW_W];
            assign data_arr[gi]  = data_i[gi*DATA_W +: DATA_W];
            assign rd_req_o[gi]  = rd_en_i && (sel_i == CH_W'(gi));
        end
    endgenerate

    // Select the status and data of the latched channel; an unmatched
    // select looks like an empty FIFO so nothing is ever read from it.
    always_comb begin
        empty_o = 1'b1;
        usedw_o = '0;
        data_o  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_i == CH_W'(i)) begin
                empty_o = empty_i[i];
                usedw_o = usedw_arr[i];
                data_o  = data_arr[i];
            end
        end
    end

endmodule

// File: rtl/upp_tx_sequencer.sv
// uPP transmit sequencer: drains one selected show-ahead FIFO onto the uPP
// bus in fixed-length lines, runs the GPIO5/GPIO0 frame handshake, pads a
// flushed partial line and flags underruns or illegal channel requests.
module upp_tx_sequencer
    import upp_tx_pkg::*;
#(
    parameter int DATA_W           = DEF_DATA_W,
    parameter int USEDW_W          = DEF_USEDW_W,
    parameter int N_CH             = DEF_N_CH,
    parameter int LINE_LEN         = DEF_LINE_LEN,
    parameter int THRESHOLD        = DEF_THRESHOLD,
    parameter int LINES_PER_FRAME  = DEF_LINES_PER_FRAME,
    parameter int START_EVERY_LINE = DEF_START_EVERY_LINE,
    parameter int CHECK_GPIO5      = DEF_CHECK_GPIO5,
    parameter int BETWEEN_FRAMES   = DEF_BETWEEN_FRAMES,
    parameter logic [DATA_W-1:0] PAD_WORD = DATA_W'(DEF_PAD_WORD),
    localparam int CH_W            = ch_width(N_CH)
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iGPIO5,
    input  logic [CH_W-1:0]         iSEL_CHANNEL,
    input  logic                    iWAIT,
    input  logic                    iFLUSH,
    input  logic [N_CH-1:0]         iEMPTY,
    input  logic [N_CH*USEDW_W-1:0] iUSEDW,
    input  logic [N_CH*DATA_W-1:0]  iFIFO_OUT,
    output logic [N_CH-1:0]         oRD_REQ,
    output logic [DATA_W-1:0]       oDATA_UPP,
    output logic                    oENA,
    output logic                    oSTART,
    output logic                    oGPIO_0,
    output logic [CH_W-1:0]         oSEL_CHANNEL,
    output logic                    oERR,
    output logic                    oBUSY
);

    localparam int WC_W  = $clog2(LINE_LEN);
    localparam int TMR_W = $clog2(max2(CHECK_GPIO5, BETWEEN_FRAMES) + 1);
    localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(LINE_LEN - 1);
    localparam logic [TMR_W-1:0] STIM_LAST = TMR_W'(CHECK_GPIO5 - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(BETWEEN_FRAMES - 1);

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         sel_q, sel_d;
    logic                    err_q, err_d;
    logic                    flush_q, flush_d;
    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    ena_q, ena_d;
    logic                    start_q, start_d;

    logic                    empty_sel;
    logic [USEDW_W-1:0]      usedw_sel;
    logic [DATA_W-1:0]       data_sel;
    logic                    rd_en;
    logic                    emit;
    logic                    chan_ok;
    logic                    frame_full;

    // A read happens only while actively draining and the receiver is not pausing.
    assign rd_en      = (state_q == ST_READ) && !iWAIT && !empty_sel;
    assign chan_ok    = int'(iSEL_CHANNEL) < N_CH;
    assign frame_full = (LINES_PER_FRAME != 0) &&
                        (({1'b0, line_cnt_q} + 17'd1) == 17'(LINES_PER_FRAME));

    upp_ch_mux #(
        .DATA_W  (DATA_W),
        .USEDW_W (USEDW_W),
        .N_CH    (N_CH),
        .CH_W    (CH_W)
    ) u_mux (
        .sel_i    (sel_q),
        .rd_en_i  (rd_en),
        .empty_i  (iEMPTY),
        .usedw_i  (iUSEDW),
        .data_i   (iFIFO_OUT),
        .empty_o  (empty_sel),
        .usedw_o  (usedw_sel),
        .data_o   (data_sel),
        .rd_req_o (oRD_REQ)
    );

    // Frame/line sequencing and the registered uPP output word.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        err_d      = err_q;
        flush_d    = flush_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        tmr_d      = tmr_q;
        data_d     = data_q;
        ena_d      = 1'b0;
        start_d    = 1'b0;
        emit       = 1'b0;

        if ((state_q == ST_ARM || state_q == ST_READ) && iFLUSH) begin
            flush_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (iGPIO5) begin
                    line_cnt_d = '0;
                    state_d    = ST_ARM;
                    if (chan_ok) begin
                        sel_d = iSEL_CHANNEL;
                        err_d = 1'b0;
                    end else begin
                        sel_d = '0;
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (usedw_sel >= USEDW_W'(THRESHOLD) || (flush_q && !empty_sel)) begin
                    state_d    = ST_READ;
                    word_cnt_d = '0;
                end else if (flush_q && empty_sel) begin
                    state_d = ST_GPIO0;
                    tmr_d   = '0;
                end
            end
            ST_READ: begin
                if (!iWAIT) begin
                    if (!empty_sel) begin
                        emit   = 1'b1;
                        data_d = data_sel;
                    end else if (flush_q) begin
                        emit   = 1'b1;
                        data_d = PAD_WORD;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (emit) begin
                        ena_d   = 1'b1;
                        start_d = (word_cnt_q == '0) &&
                                  ((START_EVERY_LINE != 0) || (line_cnt_q == '0));
                        if (word_cnt_q == WC_LAST) begin
                            line_cnt_d = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 1'b1;
                            if (frame_full) begin
                                state_d = ST_GPIO0;
                                tmr_d   = '0;
                            end else begin
                                state_d = ST_ARM;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
            end
            ST_GPIO0: begin
                if (iGPIO5) begin
                    if (tmr_q == STIM_LAST) begin
                        tmr_d  = '0;
                        ena_d  = 1'b1;
                        data_d = PAD_WORD;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end else begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                end
            end
            ST_GAP: begin
                flush_d = 1'b0;
                if (tmr_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any line in progress.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            tmr_q      <= '0;
            data_q     <= '0;
            ena_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            flush_q    <= flush_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            tmr_q      <= tmr_d;
            data_q     <= data_d;
            ena_q      <= ena_d;
            start_q    <= start_d;
        end
    end

    assign oDATA_UPP    = data_q;
    assign oENA         = ena_q;
    assign oSTART       = start_q;
    assign oGPIO_0      = (state_q == ST_GPIO0);
    assign oSEL_CHANNEL = sel_q;
    assign oERR         = err_q;
    assign oBUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_upp_tx_sequencer.sv
// Directed bench for upp_tx_sequencer: two show-ahead FIFO models feed the
// DUT, every emitted uPP word is collected and compared to hand-built values.
module tb_upp_tx_sequencer;

    localparam logic [15:0] PAD = 16'hDEAD;

    logic        clk;
    logic        iRST_N;
    logic        iGPIO5;
    logic [0:0]  iSEL_CHANNEL;
    logic        iWAIT;
    logic        iFLUSH;
    logic [1:0]  iEMPTY;
    logic [17:0] iUSEDW;
    logic [31:0] iFIFO_OUT;
    logic [1:0]  oRD_REQ;
    logic [15:0] oDATA_UPP;
    logic        oENA;
    logic        oSTART;
    logic        oGPIO_0;
    logic [0:0]  oSEL_CHANNEL;
    logic        oERR;
    logic        oBUSY;

    upp_tx_sequencer #(
        .DATA_W           (16),
        .USEDW_W          (9),
        .N_CH             (2),
        .LINE_LEN         (256),
        .THRESHOLD        (256),
        .LINES_PER_FRAME  (2),
        .START_EVERY_LINE (0),
        .CHECK_GPIO5      (100),
        .BETWEEN_FRAMES   (100),
        .PAD_WORD         (PAD)
    ) dut (
        .iCLK         (clk),
        .iRST_N       (iRST_N),
        .iGPIO5       (iGPIO5),
        .iSEL_CHANNEL (iSEL_CHANNEL),
        .iWAIT        (iWAIT),
        .iFLUSH       (iFLUSH),
        .iEMPTY       (iEMPTY),
        .iUSEDW       (iUSEDW),
        .iFIFO_OUT    (iFIFO_OUT),
        .oRD_REQ      (oRD_REQ),
        .oDATA_UPP    (oDATA_UPP),
        .oENA         (oENA),
        .oSTART       (oSTART),
        .oGPIO_0      (oGPIO_0),
        .oSEL_CHANNEL (oSEL_CHANNEL),
        .oERR         (oERR),
        .oBUSY        (oBUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fq0 [$];
    logic [15:0] fq1 [$];
    logic [15:0] out_q [$];
    logic        hold1;
    logic [1:0]  rd_acc;
    int          start_n;
    int          start_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] usedw_of(input int n);
        return (n > 511) ? 9'd511 : 9'(n);
    endfunction

    task automatic drive_fifo();
        iEMPTY[0]        = (fq0.size() == 0);
        iUSEDW[8:0]      = usedw_of(fq0.size());
        iFIFO_OUT[15:0]  = (fq0.size() != 0) ? fq0[0] : 16'h0;
        iEMPTY[1]        = hold1 || (fq1.size() == 0);
        iUSEDW[17:9]     = hold1 ? 9'd0 : usedw_of(fq1.size());
        iFIFO_OUT[31:16] = (fq1.size() != 0) ? fq1[0] : 16'h0;
    endtask

    // One clock: pop what the DUT acknowledges, then sample outputs on the falling edge.
    task automatic cyc();
        logic [1:0] rd;
        drive_fifo();
        #1;
        rd = oRD_REQ;
        rd_acc = rd_acc | rd;
        @(posedge clk);
        #1;
        if (rd[0] && fq0.size() != 0) void'(fq0.pop_front());
        if (rd[1] && fq1.size() != 0) void'(fq1.pop_front());
        drive_fifo();
        @(negedge clk);
        if (oENA) begin
            if (oSTART) begin
                start_n++;
                start_idx = out_q.size();
            end
            out_q.push_back(oDATA_UPP);
        end
    endtask

    task automatic clear_obs();
        out_q.delete();
        start_n   = 0;
        start_idx = -1;
        rd_acc    = 2'b00;
    endtask

    task automatic run_until_gpio(input int budget);
        int n = 0;
        while (!oGPIO_0 && n < budget) begin
            cyc();
            n++;
        end
    endtask

    task automatic drop_and_gap(output int n);
        iGPIO5 = 1'b0;
        cyc();
        n = 0;
        while (oBUSY && n < 500) begin
            n++;
            cyc();
        end
    endtask

    int          n;
    int          mism;
    int          ena_low;
    int          gap_len;
    logic        pushed;
    logic        waited;
    logic [1:0]  rd_save;
    logic [15:0] exp_w;

    initial begin
        iRST_N = 1'b0; iGPIO5 = 1'b0; iSEL_CHANNEL = 1'b0; iWAIT = 1'b0; iFLUSH = 1'b0;
        hold1 = 1'b0;
        clear_obs();
        drive_fifo();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rdreq", 32'(oRD_REQ), 0);
        chk("rst_data", 32'(oDATA_UPP), 0);
        chk("rst_ena", 32'(oENA), 0);
        chk("rst_start", 32'(oSTART), 0);
        chk("rst_gpio0", 32'(oGPIO_0), 0);
        chk("rst_sel", 32'(oSEL_CHANNEL), 0);
        chk("rst_err", 32'(oERR), 0);
        chk("rst_busy", 32'(oBUSY), 0);
        iRST_N = 1'b1;
        cyc();
        $display("txn reset done");

        // Frame 1: channel 1, two full lines, 5-cycle WAIT at word 100
        for (int i = 0; i < 256; i++) fq1.push_back(16'h1000 + 16'(i));
        for (int i = 0; i < 100; i++) fq0.push_back(16'(i));
        iSEL_CHANNEL = 1'b1;
        iGPIO5 = 1'b1;
        pushed = 1'b0; waited = 1'b0; n = 0;
        while (!oGPIO_0 && n < 3000) begin
            if (!pushed && out_q.size() >= 10) begin
                for (int i = 0; i < 256; i++) fq1.push_back(16'h1100 + 16'(i));
                pushed = 1'b1;
            end
            if (!waited && out_q.size() == 100) begin
                waited = 1'b1;
                rd_save = rd_acc; rd_acc = 2'b00; ena_low = 0;
                iWAIT = 1'b1;
                repeat (5) begin
                    cyc();
                    if (!oENA) ena_low++;
                end
                iWAIT = 1'b0;
                chk("wait_rdreq", 32'(rd_acc), 0);
                chk("wait_ena_low", ena_low, 5);
                chk("wait_words_held", out_q.size(), 100);
                rd_acc = rd_save;
            end
            cyc();
            n++;
        end
        mism = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            exp_w = (i < 256) ? 16'h1000 + 16'(i) : 16'h1100 + 16'(i - 256);
            if (out_q[i] !== exp_w) mism++;
        end
        chk("f1_gpio0", 32'(oGPIO_0), 1);
        chk("f1_words", out_q.size(), 512);
        chk("f1_seq_mism", mism, 0);
        chk("f1_word100", (out_q.size() > 100) ? 32'(out_q[100]) : 32'hFFFF_FFFF, 32'h1064);
        chk("f1_start_n", start_n, 1);
        chk("f1_start_idx", start_idx, 0);
        chk("f1_rdreq_ch", 32'(rd_acc), 32'h2);
        chk("f1_ch0_untouched", fq0.size(), 100);
        chk("f1_err", 32'(oERR), 0);
        chk("f1_sel", 32'(oSEL_CHANNEL), 1);
        $display("txn frame1 words=%0d starts=%0d", out_q.size(), start_n);

        // GPIO0 stimulus: GPIO5 held 250 cycles, then the inter-frame gap
        clear_obs();
        repeat (250) cyc();
        chk("stim_pulses", out_q.size(), 2);
        chk("stim_word0", (out_q.size() > 0) ? 32'(out_q[0]) : 32'hFFFF_FFFF, 32'(PAD));
        chk("stim_gpio0_held", 32'(oGPIO_0), 1);
        drop_and_gap(gap_len);
        chk("gap_len", gap_len, 100);
        chk("gap_idle", 32'(oBUSY), 0);
        $display("txn gpio0 pulses=%0d gap=%0d", out_q.size(), gap_len);

        // Frame 2: channel 0, 40 words then flush -> padded line
        clear_obs();
        fq0.delete();
        for (int i = 0; i < 40; i++) fq0.push_back(16'h2000 + 16'(i));
        iSEL_CHANNEL = 1'b0;
        iGPIO5 = 1'b1;
        repeat (5) cyc();
        chk("fl_armed_no_words", out_q.size(), 0);
        chk("fl_armed_busy", 32'(oBUSY), 1);
        iFLUSH = 1'b1;
        cyc();
        iFLUSH = 1'b0;
        run_until_gpio(1000);
        mism = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            exp_w = (i < 40) ? 16'h2000 + 16'(i) : PAD;
            if (out_q[i] !== exp_w) mism++;
        end
        chk("fl_gpio0", 32'(oGPIO_0), 1);
        chk("fl_words", out_q.size(), 256);
        chk("fl_seq_mism", mism, 0);
        chk("fl_start_n", start_n, 1);
        chk("fl_rdreq_ch", 32'(rd_acc), 32'h1);
        chk("fl_err", 32'(oERR), 0);
        drop_and_gap(gap_len);
        chk("fl_idle", 32'(oBUSY), 0);
        $display("txn flush words=%0d", out_q.size());

        // Frame 3: channel 1 underrun mid-line without flush
        clear_obs();
        fq1.delete();
        for (int i = 0; i < 256; i++) fq1.push_back(16'h3000 + 16'(i));
        iSEL_CHANNEL = 1'b1;
        iGPIO5 = 1'b1;
        n = 0;
        while (out_q.size() < 50 && n < 500) begin
            cyc();
            n++;
        end
        hold1 = 1'b1;
        rd_acc = 2'b00;
        repeat (6) cyc();
        chk("ur_rdreq", 32'(rd_acc), 0);
        chk("ur_stalled", out_q.size(), 50);
        chk("ur_err", 32'(oERR), 1);
        hold1 = 1'b0;
        n = 0;
        while (out_q.size() < 256 && n < 500) begin
            cyc();
            n++;
        end
        mism = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i] !== 16'h3000 + 16'(i)) mism++;
        end
        chk("ur_words", out_q.size(), 256);
        chk("ur_seq_mism", mism, 0);
        repeat (3) cyc();
        chk("ur_wait_line1", 32'(oGPIO_0), 0);
        iFLUSH = 1'b1;
        cyc();
        iFLUSH = 1'b0;
        run_until_gpio(20);
        chk("ur_flush_gpio0", 32'(oGPIO_0), 1);
        chk("ur_no_pad", out_q.size(), 256);
        chk("ur_err_sticky", 32'(oERR), 1);
        drop_and_gap(gap_len);
        $display("txn underrun words=%0d", out_q.size());

        // Frame 4: async reset in the middle of a line
        clear_obs();
        fq1.delete();
        for (int i = 0; i < 256; i++) fq1.push_back(16'h4000 + 16'(i));
        iSEL_CHANNEL = 1'b1;
        iGPIO5 = 1'b1;
        cyc();
        chk("f4_err_cleared", 32'(oERR), 0);
        n = 0;
        while (out_q.size() < 20 && n < 500) begin
            cyc();
            n++;
        end
        chk("f4_pre_data", 32'(oDATA_UPP), 32'h4013);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("ar_rdreq", 32'(oRD_REQ), 0);
        chk("ar_data", 32'(oDATA_UPP), 0);
        chk("ar_ena", 32'(oENA), 0);
        chk("ar_start", 32'(oSTART), 0);
        chk("ar_gpio0", 32'(oGPIO_0), 0);
        chk("ar_sel", 32'(oSEL_CHANNEL), 0);
        chk("ar_err", 32'(oERR), 0);
        chk("ar_busy", 32'(oBUSY), 0);
        $display("txn async reset mid-line");
        repeat (2) @(negedge clk);
        iRST_N = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
